// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - round-robin payload scheduler feeding a UDP transmitter
// Grants one requester per frame, holds tx_send until the transmitter drops ready, then enforces an inter-frame gap.
module udp_tx_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_BYTES   = 16,
  parameter int GAP_CYCLES   = 96,
  parameter int SEND_TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              req,
  input  logic [NUM_SRC*8*DATA_BYTES-1:0] payload,
  output logic [NUM_SRC-1:0]              ack,
  output logic [8*DATA_BYTES-1:0]         tx_data,
  output logic                            tx_send,
  input  logic                            tx_ready,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [15:0]                     frame_count
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TW = $clog2(SEND_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [SW-1:0] LAST_SRC = SW'(NUM_SRC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(SEND_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   last_grant, winner;
  logic            found, grant;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;

  // Round-robin search begins one past the previous winner.
  always_comb begin
    int idx;
    idx    = 0;
    winner = last_grant;
    found  = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req[idx[SW-1:0]]) begin
        found  = 1'b1;
        winner = idx[SW-1:0];
      end
    end
  end

  assign grant = (state == IDLE) && tx_ready && found && !reset;
  assign busy  = (state != IDLE);

  always_comb begin
    ack = '0;
    if (grant) ack[winner] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant) state_next = SEND;
      SEND:      if (!tx_ready) state_next = WAIT_DONE;
                 else if (to_cnt == TO_LAST) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      WAIT_DONE: if (tx_ready) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_cnt <= GW'(1)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= LAST_SRC;
      tx_data     <= '0;
      tx_send     <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_next;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          last_grant <= winner;
          tx_data    <= payload[int'(winner)*DW +: DW];
          tx_send    <= 1'b1;
          to_cnt     <= '0;
        end
        SEND: if (!tx_ready) begin
          tx_send     <= 1'b0;
          frame_count <= frame_count + 16'd1;
        end else if (to_cnt == TO_LAST) begin
          tx_send     <= 1'b0;
          timeout_err <= 1'b1;
          gap_cnt     <= GAP_LOAD;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
        WAIT_DONE: if (tx_ready) gap_cnt <= GAP_LOAD;
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - randomized scoreboard bench for udp_tx_scheduler
module tb_udp_tx_scheduler;
  localparam int N   = 4;
  localparam int DB  = 16;
  localparam int DW  = 8 * DB;
  localparam int GAP = 96;
  localparam int TO  = 16;

  typedef struct { int dur; bit to; } send_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [DW-1:0]   pl [N];
  logic [N*DW-1:0] payload;
  logic [N-1:0]    ack;
  logic [DW-1:0]   tx_data;
  logic            tx_send, busy, timeout_err;
  logic            tx_ready = 1'b0;
  logic [15:0]     frame_count;

  int n_chk = 0, n_fail = 0;
  int src_mode = 0;
  bit tx_en = 0, idle_ready = 0;
  logic [N-1:0] last_ack = '0;
  int frames_done = 0;

  logic [DW-1:0] exp_data [$];
  send_t         exp_send [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pl
    assign payload[g*DW +: DW] = pl[g];
  end

  udp_tx_scheduler #(.NUM_SRC(N), .DATA_BYTES(DB), .GAP_CYCLES(GAP), .SEND_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .payload(payload), .ack(ack),
    .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready), .busy(busy),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int s = 1; s <= N; s++) begin
      if (r[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  task automatic raise(input int i);
    pl[i]  = {$urandom, $urandom, $urandom, $urandom};
    req[i] = 1'b1;
  endtask

  // Requesters: drop on ack, otherwise behave per src_mode.
  initial begin
    for (int i = 0; i < N; i++) pl[i] = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_ack[i]) req[i] = 1'b0;
        else if (src_mode == 1) begin
          if (!req[i] && $urandom_range(0, 3) == 0) raise(i);
          else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
        end else if (src_mode == 2) begin
          if (!req[i]) raise(i);
        end else if (src_mode == 3) begin
          if (i == 1 && req == '0) raise(i);
        end
      end
    end
  end

  // Transmitter model: accepts after d cycles of tx_send, or never (timeout).
  bit t_to;
  int t_d, t_guard;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_en && tx_send && !reset) begin
        t_to = ($urandom_range(0, 4) == 0);
        t_d  = $urandom_range(1, 4);
        exp_send.push_back('{t_to ? TO : t_d + 1, t_to});
        if (!t_to) begin
          repeat (t_d) @(posedge clk);
          #1 tx_ready = 1'b0;
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1 tx_ready = 1'b1;
        end else begin
          t_guard = 0;
          while (tx_send && t_guard < 4 * TO) begin
            @(posedge clk); #1;
            t_guard++;
          end
        end
      end else begin
        tx_ready = idle_ready;
      end
    end
  end

  // Monitor / scoreboard.
  int cyc = 0, m_last = N - 1, m_frames = 0, send_len = 0, gap_start = 0, gap_exp = 0, w;
  bit prev_send = 0, prev_busy = 0, pending = 0, gap_armed = 0, fell;
  logic [N-1:0]  e_ack;
  logic [DW-1:0] cur_data = '0;
  send_t         es;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      last_ack = ack;
      if (reset) begin
        m_last = N - 1; m_frames = 0; pending = 0; gap_armed = 0;
        prev_send = 0; prev_busy = 0;
        exp_data.delete(); exp_send.delete();
        continue;
      end
      if (ack != '0) begin
        w = rr_pick(req, m_last);
        e_ack = '0;
        if (w >= 0) e_ack[w] = 1'b1;
        chk(ack == e_ack, "rr_grant", DW'(ack), DW'(e_ack));
        chk(tx_ready == 1'b1, "grant_needs_ready", DW'(tx_ready), DW'(1));
        if (w >= 0) begin
          exp_data.push_back(pl[w]);
          m_last = w;
        end
      end else if (!busy && tx_ready && req != '0) begin
        chk(1'b0, "missed_grant", DW'(ack), DW'(req));
      end
      if (tx_send && !prev_send) begin
        send_len = 0;
        if (exp_data.size() == 0) chk(1'b0, "send_without_grant", DW'(1), DW'(0));
        else begin
          cur_data = exp_data.pop_front();
          chk(tx_data == cur_data, "tx_data", tx_data, cur_data);
        end
      end
      if (tx_send) send_len++;
      fell = !tx_send && prev_send;
      if (fell) begin
        frames_done++;
        if (exp_send.size() == 0) chk(1'b0, "unexpected_send_end", DW'(send_len), DW'(0));
        else begin
          es = exp_send.pop_front();
          chk(send_len == es.dur, "send_len", DW'(send_len), DW'(es.dur));
          chk(timeout_err == es.to, "timeout_err", DW'(timeout_err), DW'(es.to));
          if (!es.to) m_frames++;
          chk(frame_count == 16'(m_frames), "frame_count", DW'(frame_count), DW'(16'(m_frames)));
          chk(tx_data == cur_data, "tx_data_hold", tx_data, cur_data);
          if (es.to) begin
            gap_start = cyc; gap_exp = GAP; gap_armed = 1;
          end else pending = 1;
        end
      end else if (timeout_err) begin
        chk(1'b0, "spurious_timeout", DW'(1), DW'(0));
      end
      if (pending && tx_ready) begin
        gap_start = cyc; gap_exp = GAP + 1; gap_armed = 1; pending = 0;
      end
      if (!busy && prev_busy && gap_armed) begin
        chk(cyc - gap_start == gap_exp, "gap_len", DW'(cyc - gap_start), DW'(gap_exp));
        gap_armed = 0;
      end
      prev_send = tx_send;
      prev_busy = busy;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int guard, base;
  bit hit;
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(tx_send == 0, "rst_tx_send", DW'(tx_send), DW'(0));
    chk(ack == 0, "rst_ack", DW'(ack), DW'(0));
    chk(busy == 0, "rst_busy", DW'(busy), DW'(0));
    chk(tx_data == 0, "rst_tx_data", tx_data, DW'(0));
    chk(frame_count == 0, "rst_frame_count", DW'(frame_count), DW'(0));
    chk(timeout_err == 0, "rst_timeout_err", DW'(timeout_err), DW'(0));
    @(posedge clk); #1 reset = 1'b0;

    src_mode = 3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(req == 4'b0010, "ready_low_req", DW'(req), DW'(4'b0010));
    chk(ack == 0 && tx_send == 0, "ready_low_hold", DW'({ack, tx_send}), DW'(0));
    idle_ready = 1; tx_en = 1;
    @(posedge clk); #2;
    @(negedge clk);
    chk(ack == 4'b0010, "grant_after_ready", DW'(ack), DW'(4'b0010));
    src_mode = 1;

    guard = 0;
    while (frames_done < 40 && guard < 20000) begin
      @(posedge clk); guard++;
    end
    chk(frames_done >= 40, "random_frames_budget", DW'(frames_done), DW'(40));

    src_mode = 2;
    guard = 0; hit = 0;
    while (!hit && guard < 3000) begin
      @(posedge clk); #2;
      hit = busy && !tx_send && !tx_ready;
      guard++;
    end
    chk(hit, "reach_wait_done", DW'(hit), DW'(1));
    #1 reset = 1'b1;
    #1;
    chk(tx_send == 0 && busy == 0 && ack == 0 && timeout_err == 0, "midframe_rst_ctrl",
        DW'({tx_send, busy, ack, timeout_err}), DW'(0));
    chk(tx_data == 0, "midframe_rst_data", tx_data, DW'(0));
    chk(frame_count == 0, "midframe_rst_count", DW'(frame_count), DW'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    guard = 0; hit = 0;
    while (!hit && guard < 50) begin
      @(negedge clk);
      hit = (ack != 0);
      guard++;
    end
    chk(ack == 4'b0001, "first_after_reset", DW'(ack), DW'(4'b0001));

    base = frames_done;
    src_mode = 1;
    guard = 0;
    while (frames_done < base + 4 && guard < 3000) begin
      @(posedge clk); guard++;
    end
    chk(frames_done >= base + 4, "post_reset_frames", DW'(frames_done), DW'(base + 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_tx_scheduler.md
UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of payload requesters (2..8).
REQ-002 SHALL have parameter DATA_BYTES, default 16, payload bytes per frame; matches the UDP transmitter.
REQ-003 SHALL have parameter GAP_CYCLES, default 96, minimum idle clk cycles between frames (0 allowed).
REQ-004 SHALL have parameter SEND_TIMEOUT, default 1024, max clk cycles tx_send is held without acceptance.
REQ-005 SHALL have port clk  input  1  system clock; one clock domain.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req  input  NUM_SRC  per-source frame request, level, held until ack.
REQ-008 SHALL have port payload  input  NUM_SRC*8*DATA_BYTES  source i payload at bits [i*8*DATA_BYTES +: 8*DATA_BYTES].
REQ-009 SHALL have port ack  output  NUM_SRC  one-cycle pulse; payload of that source latched.
REQ-010 SHALL have port tx_data  output  8*DATA_BYTES  payload to the transmitter's data input.
REQ-011 SHALL have port tx_send  output  1  to the transmitter's send input.
REQ-012 SHALL have port tx_ready  input  1  from the transmitter's ready output.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on send timeout.
REQ-015 SHALL have port frame_count  output  16  count of frames accepted by the transmitter.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT_DONE, GAP.
REQ-017 In IDLE with tx_ready=1 and req!=0, SHALL in one cycle: select the winner, latch its payload into tx_data, pulse its ack bit, set tx_send=1, and enter SEND.
REQ-018 In IDLE with tx_ready=0, SHALL grant nothing and stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_SRC; last_grant updates only on grant.
REQ-020 At most one ack bit SHALL be high in any cycle; ack SHALL never be high for a source whose req is 0.
REQ-021 tx_data SHALL stay stable from grant until the next grant.
REQ-022 In SEND, tx_send SHALL be held at 1 until a cycle sampling tx_ready=0; then tx_send=0, frame_count+1 (wraps 0xFFFF->0), and the FSM enters WAIT_DONE.
REQ-023 In SEND, if tx_ready stays 1 for SEND_TIMEOUT cycles after entry, SHALL drop tx_send, pulse timeout_err, leave frame_count unchanged, and enter GAP.
REQ-024 In WAIT_DONE, SHALL stay until tx_ready=1, then enter GAP with the gap counter loaded to GAP_CYCLES.
REQ-025 In GAP, SHALL decrement the counter each cycle and enter IDLE when it reaches 0; with GAP_CYCLES=0, SHALL enter IDLE directly from WAIT_DONE/timeout.
REQ-026 A req deasserted before grant SHALL be dropped silently; a req change during SEND/WAIT_DONE/GAP SHALL not affect the current frame.
REQ-027 Counters SHALL use $clog2-sized widths with no truncation at the default parameters.

Reset
REQ-028 While reset=1, SHALL force state=IDLE, tx_send=0, ack=0, timeout_err=0, busy=0, tx_data=0, frame_count=0, gap/timeout counters=0, last_grant=NUM_SRC-1 (source 0 wins first).
REQ-029 Reset asserted mid-frame SHALL take effect asynchronously; after release, the FSM SHALL wait in IDLE for tx_ready=1 before the next grant.

Verification
REQ-030 Single source: req=4'b0001, tx_ready=1, transmitter drops ready 2 cycles after send -> ack[0] one pulse, tx_send high exactly 3 cycles, frame_count=1.
REQ-031 Round-robin: req=4'b1111 held, 8 frames -> ack order 0,1,2,3,0,1,2,3; tx_data equals the granted source's payload each frame.
REQ-032 Gap: GAP_CYCLES=96, two back-to-back requests -> second grant no earlier than 96 cycles after tx_ready returns high.
REQ-033 Timeout: SEND_TIMEOUT=16, tx_ready held 1 -> tx_send falls after 16 cycles, timeout_err one pulse, frame_count unchanged.
REQ-034 Reset mid-frame: assert reset in WAIT_DONE -> all outputs at reset values immediately, next grant goes to source 0.
REQ-035 Ready low: tx_ready=0 with req=4'b0010 -> no ack and tx_send=0 until tx_ready=1, then grant within 1 cycle.
